// File: rtl/cp0_pkg.sv
// cp0_pkg: shared types and constants for the CP0 external-interrupt path.
// Holds the controller state encoding, the interrupt ExcCode and the default source count.
// Imported by the interface, the edge detector and the interrupt controller top.
package cp0_pkg;

    // Controller state: waiting for a source, requesting CP0, or handler running.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // CP0 Cause.ExcCode value used for external interrupts.
    localparam logic [4:0] EXC_INT = 5'b00000;

    // Default number of external interrupt sources.
    localparam int DEFAULT_N_IRQ = 6;

endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: groups the I/O-side and CP0-side signals of the interrupt controller.
// master: the controller (drives int_req/int_id/read-back); slave: CP0 and I/O side.
// Signals: irq_in, mask_we, mask_wdata, int_ack, eret in; int_req, int_id, mask_out, pending_out, in_service out.
interface interrupt_controller_if
    import cp0_pkg::*;
#(
    parameter int N_IRQ = DEFAULT_N_IRQ,
    parameter int ID_W  = 3
);
    logic [N_IRQ-1:0] irq_in;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             int_ack;
    logic             eret;
    logic             int_req;
    logic [ID_W-1:0]  int_id;
    logic [N_IRQ-1:0] mask_out;
    logic [N_IRQ-1:0] pending_out;
    logic             in_service;

    modport master (
        input  irq_in, mask_we, mask_wdata, int_ack, eret,
        output int_req, int_id, mask_out, pending_out, in_service
    );

    modport slave (
        output irq_in, mask_we, mask_wdata, int_ack, eret,
        input  int_req, int_id, mask_out, pending_out, in_service
    );
endinterface

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: per-bit two-flop synchroniser plus history flop and rising-edge detector.
// Ports: clock, reset (sync, active-high), d = raw async lines, rise = one-cycle edge pulses.
// Latency: a line high before edge E1 shows as a rise pulse after E2 (consumed at E3).
module irq_sync_edge #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;
    logic [1:0]   arm_cnt;
    logic         armed;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            arm_cnt <= 2'd0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
            if (arm_cnt != 2'd3) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
        end
    end

    // The chain is cleared by reset, so a line that is already high would look
    // like a fresh edge while s1..s3 refill. Edges are only reported once the
    // history flop holds a real sample (three clocks after reset), so lines high
    // through reset never create a pending event.
    assign armed = (arm_cnt == 2'd3);
    assign rise  = s2 & ~s3 & {W{armed}};

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: collects peripheral IRQs into a pending register, masks them,
// picks the lowest-index eligible source and holds a request to CP0 until ack, then waits for eret.
// Ports: clock, reset (sync, active-high), bus (master modport: irq/mask/ack/eret in, req/id/readback out).
module interrupt_controller
    import cp0_pkg::*;
#(
    parameter int N_IRQ = DEFAULT_N_IRQ,
    parameter int ID_W  = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    interrupt_controller_if.master bus
);
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] ack_clr;

    state_t           state;
    logic             int_req_q;
    logic             in_service_q;
    logic [ID_W-1:0]  int_id_q;

    // Fixed priority: the lowest set index wins.
    function automatic logic [ID_W-1:0] prio_enc(input logic [N_IRQ-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = ID_W'(i);
            end
        end
        return r;
    endfunction

    irq_sync_edge #(
        .W(N_IRQ)
    ) u_sync_edge (
        .clock (clock),
        .reset (reset),
        .d     (bus.irq_in),
        .rise  (rise)
    );

    assign eligible = pending & mask;

    // Pending bit to clear when CP0 accepts the outstanding request.
    always_comb begin
        ack_clr = '0;
        if (state == REQ && bus.int_ack) begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (ID_W'(i) == int_id_q) begin
                    ack_clr[i] = 1'b1;
                end
            end
        end
    end

    // A new edge in the same cycle as the ack clear wins, so the source
    // is not lost if it re-fires while being acknowledged.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= (pending & ~ack_clr) | rise;
            if (bus.mask_we) begin
                mask <= bus.mask_wdata;
            end
        end
    end

    // Request/service sequencer. int_id is latched on entry to REQ and held
    // through SERVICE, so mask writes or higher-priority edges cannot retarget
    // a request CP0 may already be acting on.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b0;
            int_id_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        int_id_q  <= prio_enc(eligible);
                        int_req_q <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.int_ack) begin
                        int_req_q    <= 1'b0;
                        in_service_q <= 1'b1;
                        state        <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (bus.eret) begin
                        in_service_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    int_req_q    <= 1'b0;
                    in_service_q <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.int_req     = int_req_q;
    assign bus.int_id      = int_id_q;
    assign bus.in_service  = in_service_q;
    assign bus.mask_out    = mask;
    assign bus.pending_out = pending;

endmodule
